// File: rtl/risc_v_mike_uart_mmio_fifo.sv
// Purpose: MMIO bridge between the core data port and UART TX/RX engines, with
//   TX/RX FIFOs, autonomous flag handshakes, sticky errors and a level irq.
// Ports: data_mmio_* (register access, combinational read data), tx_*/rx_* (UART
//   engine handshake), parity_error, irq (registered level); clk, rst (async, active-low).
module risc_v_mike_uart_mmio_fifo #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       data_mmio_addr,
  input  logic              data_mmio_wr_addr_val,
  input  logic              data_mmio_rd_val,
  input  logic [31:0]       data_mmio_wr_data,
  output logic [31:0]       data_mmio_rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_send,
  input  logic              tx_flag,
  output logic              tx_flag_clr,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_flag,
  input  logic              parity_error,
  output logic              rx_flag_clr,
  output logic              irq
);

  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int TX_CW = $clog2(TX_DEPTH + 1);
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam int RX_CW = $clog2(RX_DEPTH + 1);

  localparam logic [31:0] A_TXDATA = 32'h00;
  localparam logic [31:0] A_RXDATA = 32'h04;
  localparam logic [31:0] A_STATUS = 32'h08;
  localparam logic [31:0] A_STCLR  = 32'h0C;
  localparam logic [31:0] A_IRQEN  = 32'h10;

  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_CLR} tx_st_t;
  typedef enum logic {R_IDLE, R_CLR} rx_st_t;

  // FIFO storage and pointers
  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [TX_PW-1:0]  tx_wp_q, tx_rp_q;
  logic [RX_PW-1:0]  rx_wp_q, rx_rp_q;
  logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;

  tx_st_t            tx_st_q, tx_st_d;
  rx_st_t            rx_st_q, rx_st_d;
  logic [DATA_W-1:0] tx_dat_q, tx_dat_d;
  logic              tx_send_q, tx_send_d, tx_clr_q, tx_clr_d, rx_clr_q, rx_clr_d;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, par_q, par_d;
  logic [2:0]        irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_pop, rx_push_req, rx_push, rx_pop, stclr;

  assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_push_req = data_mmio_wr_addr_val && (data_mmio_addr == A_TXDATA);
  // A push into a full FIFO still lands if the same edge frees a slot
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop      = data_mmio_rd_val && (data_mmio_addr == A_RXDATA) && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign stclr       = data_mmio_wr_addr_val && (data_mmio_addr == A_STCLR);

  // TX handshake: pop head into the holding register, then wait for done/clear
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_dat_d  = tx_dat_q;
    tx_send_d = tx_send_q;
    tx_clr_d  = tx_clr_q;
    tx_pop    = 1'b0;
    case (tx_st_q)
      T_IDLE: if (!tx_empty) begin
        tx_pop    = 1'b1;
        tx_dat_d  = tx_mem_q[tx_rp_q];
        tx_send_d = 1'b1;
        tx_st_d   = T_WAIT;
      end
      T_WAIT: if (tx_flag) begin
        tx_send_d = 1'b0;
        tx_clr_d  = 1'b1;
        tx_st_d   = T_CLR;
      end
      T_CLR: if (!tx_flag) begin
        tx_clr_d = 1'b0;
        tx_st_d  = T_IDLE;
      end
      default: tx_st_d = T_IDLE;
    endcase
  end

  // RX handshake: one push per rx_flag assertion, then hold clear until flag drops
  always_comb begin
    rx_st_d     = rx_st_q;
    rx_clr_d    = rx_clr_q;
    rx_push_req = 1'b0;
    case (rx_st_q)
      R_IDLE: if (rx_flag) begin
        rx_push_req = 1'b1;
        rx_clr_d    = 1'b1;
        rx_st_d     = R_CLR;
      end
      R_CLR: if (!rx_flag) begin
        rx_clr_d = 1'b0;
        rx_st_d  = R_IDLE;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_comb begin
    tx_cnt_d = tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
    // Set terms are OR-ed after the clear so a same-cycle set wins
    tx_ovf_d = (tx_ovf_q && !(stclr && data_mmio_wr_data[6])) || (tx_push_req && !tx_push);
    rx_ovf_d = (rx_ovf_q && !(stclr && data_mmio_wr_data[5])) || (rx_push_req && !rx_push);
    par_d    = (par_q    && !(stclr && data_mmio_wr_data[7])) || (rx_push_req && parity_error);
    irq_en_d = irq_en_q;
    if (data_mmio_wr_addr_val && (data_mmio_addr == A_IRQEN)) irq_en_d = data_mmio_wr_data[2:0];
    // Sourced from current register state, so irq lags its condition by one cycle
    irq_d = |(irq_en_q & {tx_ovf_q || rx_ovf_q || par_q, tx_empty, !rx_empty});
  end

  always_comb begin
    data_mmio_rd_data = 32'hDEADBEEF;
    case (data_mmio_addr)
      A_TXDATA: data_mmio_rd_data = 32'h0;
      A_RXDATA: data_mmio_rd_data = rx_empty ? 32'h0 : 32'(rx_mem_q[rx_rp_q]);
      A_STATUS: data_mmio_rd_data = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q), par_q, tx_ovf_q, rx_ovf_q,
                                     (tx_st_q != T_IDLE), rx_empty, rx_full, tx_empty, tx_full};
      A_STCLR:  data_mmio_rd_data = 32'h0;
      A_IRQEN:  data_mmio_rd_data = {29'h0, irq_en_q};
      default:  data_mmio_rd_data = 32'hDEADBEEF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= data_mmio_wr_data[DATA_W-1:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
      tx_st_q <= T_IDLE; rx_st_q <= R_IDLE;
      tx_dat_q <= '0; tx_send_q <= 1'b0; tx_clr_q <= 1'b0; rx_clr_q <= 1'b0;
      tx_ovf_q <= 1'b0; rx_ovf_q <= 1'b0; par_q <= 1'b0;
      irq_en_q <= '0; irq_q <= 1'b0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + TX_PW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + TX_PW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + RX_PW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RX_PW'(1);
      tx_cnt_q <= tx_cnt_d; rx_cnt_q <= rx_cnt_d;
      tx_st_q <= tx_st_d; rx_st_q <= rx_st_d;
      tx_dat_q <= tx_dat_d; tx_send_q <= tx_send_d; tx_clr_q <= tx_clr_d; rx_clr_q <= rx_clr_d;
      tx_ovf_q <= tx_ovf_d; rx_ovf_q <= rx_ovf_d; par_q <= par_d;
      irq_en_q <= irq_en_d; irq_q <= irq_d;
    end
  end

  assign tx_data     = tx_dat_q;
  assign tx_send     = tx_send_q;
  assign tx_flag_clr = tx_clr_q;
  assign rx_flag_clr = rx_clr_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_risc_v_mike_uart_mmio_fifo.sv
module tb_risc_v_mike_uart_mmio_fifo;
  localparam int DATA_W = 8, TX_DEPTH = 8, RX_DEPTH = 8;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rd_data;
  logic wr = 1'b0, rd = 1'b0;
  logic [DATA_W-1:0] tx_data, rx_data = '0;
  logic tx_send, tx_flag, tx_flag_clr, rx_flag = 1'b0, parity_error = 1'b0, rx_flag_clr, irq;
  logic uart_flag = 1'b0, noise_flag = 1'b0, uart_tx_en = 1'b0;
  assign tx_flag = uart_flag | noise_flag;

  risc_v_mike_uart_mmio_fifo #(.DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst(rst), .data_mmio_addr(addr), .data_mmio_wr_addr_val(wr),
    .data_mmio_rd_val(rd), .data_mmio_wr_data(wdata), .data_mmio_rd_data(rd_data),
    .tx_data(tx_data), .tx_send(tx_send), .tx_flag(tx_flag), .tx_flag_clr(tx_flag_clr),
    .rx_data(rx_data), .rx_flag(rx_flag), .parity_error(parity_error),
    .rx_flag_clr(rx_flag_clr), .irq(irq));

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  // UART TX engine model: raises tx_flag after tx_send has been high 5 cycles,
  // drops it when tx_flag_clr is seen; logs characters and hold violations.
  logic [7:0] tx_seen[$];
  logic [7:0] cur = '0;
  int dly = 0, hold_err = 0, clr_pulses = 0, first_send_cyc = -1;
  bit prev_clr = 1'b0;
  initial forever begin
    @(posedge clk); #2;
    if (!rst) begin
      dly = 0; uart_flag = 1'b0;
    end else begin
      if (tx_flag_clr && !prev_clr) clr_pulses++;
      if (((tx_send && dly != 0) || tx_flag_clr) && tx_data != cur) hold_err++;
      if (uart_flag && tx_flag_clr) uart_flag = 1'b0;
      else if (tx_send && uart_tx_en && !uart_flag) begin
        if (dly == 0) begin
          cur = tx_data;
          if (tx_seen.size() == 0) first_send_cyc = cyc;
          tx_seen.push_back(tx_data);
        end
        dly++;
        if (dly == 5) begin uart_flag = 1'b1; dly = 0; end
      end
    end
    prev_clr = tx_flag_clr;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1; wr = 1'b0;
  endtask

  task automatic mmio_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk); addr = a; rd = 1'b1; #1;
    check(nm, rd_data, exp);
    @(posedge clk); #1; rd = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; wr = 1'b0; rd = 1'b0; rx_flag = 1'b0; uart_tx_en = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  // Deliver one RX character; optionally read RXDATA in the cycle rx_flag rises
  task automatic rx_deliver(input logic [7:0] d, input bit p, input bit with_rd,
                            input logic [31:0] exp_head);
    int n;
    @(negedge clk); rx_data = d; parity_error = p; rx_flag = 1'b1;
    if (with_rd) begin
      addr = 32'h04; rd = 1'b1; #1;
      check("rx_simul_head", rd_data, exp_head);
    end
    @(posedge clk); #1; rd = 1'b0;
    check("rx_flag_clr_rise", {31'h0, rx_flag_clr}, 32'h1);
    rx_flag = 1'b0; parity_error = 1'b0;
    n = 0;
    while (rx_flag_clr && n < 20) begin @(posedge clk); #1; n++; end
    check("rx_flag_clr_fall", {31'h0, rx_flag_clr}, 32'h0);
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int n, base_clr, first_wr_cyc;
    tbl[0]  = '{0, 1, 32'h40, 32'h0,        32'hDEADBEEF};
    tbl[1]  = '{0, 1, 32'h08, 32'h0,        32'h0000000A};
    tbl[2]  = '{0, 1, 32'h10, 32'h0,        32'h0};
    tbl[3]  = '{1, 0, 32'h10, 32'hFFFFFFFF, 32'h0};
    tbl[4]  = '{0, 1, 32'h10, 32'h0,        32'h7};
    tbl[5]  = '{1, 0, 32'h10, 32'h0,        32'h0};
    tbl[6]  = '{0, 1, 32'h10, 32'h0,        32'h0};
    tbl[7]  = '{0, 1, 32'h00, 32'h0,        32'h0};
    tbl[8]  = '{0, 1, 32'h04, 32'h0,        32'h0};
    tbl[9]  = '{0, 1, 32'h14, 32'h0,        32'hDEADBEEF};
    tbl[10] = '{1, 0, 32'h14, 32'h12345678, 32'h0};
    tbl[11] = '{0, 1, 32'h08, 32'h0,        32'h0000000A};

    // Reset with noisy inputs: outputs stay 0, STATUS reads empty/empty
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      addr = 32'($urandom_range(0, 5) * 4); wdata = $urandom; wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1)); rx_data = 8'($urandom); rx_flag = 1'($urandom_range(0, 1));
      parity_error = 1'($urandom_range(0, 1)); noise_flag = 1'($urandom_range(0, 1));
      #1 check("reset_outputs", 32'({tx_data, tx_send, tx_flag_clr, rx_flag_clr, irq}), 32'h0);
    end
    @(negedge clk);
    wr = 0; rd = 0; rx_flag = 0; parity_error = 0; noise_flag = 0; addr = 32'h08;
    #1 check("reset_status", rd_data, 32'h0000000A);
    @(negedge clk); rst = 1'b1;

    // Register map vectors
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) mmio_wr(tbl[i].addr, tbl[i].wdata);
      if (tbl[i].rd) mmio_rd($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // TX burst with UART model responding
    uart_tx_en = 1'b1;
    base_clr = clr_pulses;
    mmio_wr(32'h00, 32'h41);
    first_wr_cyc = cyc;
    mmio_wr(32'h00, 32'h42);
    mmio_wr(32'h00, 32'h43);
    n = 0;
    while (!(tx_seen.size() >= 3 && clr_pulses - base_clr >= 3 && !tx_flag_clr) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("tx_burst_done", {31'h0, n < 300}, 32'h1);
    check("tx_first_latency", 32'(first_send_cyc - first_wr_cyc), 32'h1);
    check("tx_char0", 32'(tx_seen.size() > 0 ? tx_seen[0] : 8'h00), 32'h41);
    check("tx_char1", 32'(tx_seen.size() > 1 ? tx_seen[1] : 8'h00), 32'h42);
    check("tx_char2", 32'(tx_seen.size() > 2 ? tx_seen[2] : 8'h00), 32'h43);
    check("tx_clr_pulses", 32'(clr_pulses - base_clr), 32'h3);
    check("tx_hold", 32'(hold_err), 32'h0);
    cycles(2);
    mmio_rd("tx_burst_status", 32'h08, 32'h0000000A);
    uart_tx_en = 1'b0;

    // TX overflow with UART silent
    for (int i = 0; i < TX_DEPTH + 2; i++) mmio_wr(32'h00, 32'(8'h60 + i));
    mmio_rd("tx_ovf_status", 32'h08, 32'h00000859);
    mmio_wr(32'h0C, 32'h40);
    mmio_rd("tx_ovf_clr_status", 32'h08, 32'h00000819);
    check("tx_send_before_rst", {31'h0, tx_send}, 32'h1);
    do_reset();
    #1 check("tx_send_after_rst", {31'h0, tx_send}, 32'h0);
    mmio_rd("post_rst_status", 32'h08, 32'h0000000A);

    // RX path with parity error on second character
    rx_deliver(8'h55, 1'b0, 1'b0, 32'h0);
    rx_deliver(8'hAA, 1'b1, 1'b0, 32'h0);
    mmio_rd("rx_status2", 32'h08, 32'h00020082);
    mmio_rd("rx_read0", 32'h04, 32'h55);
    mmio_rd("rx_read1", 32'h04, 32'hAA);
    mmio_rd("rx_read_empty", 32'h04, 32'h0);
    mmio_rd("rx_status_empty", 32'h08, 32'h0000008A);

    // RX full with simultaneous pop, then overflow without pop
    do_reset();
    for (int i = 0; i < RX_DEPTH; i++) rx_deliver(8'(i + 1), 1'b0, 1'b0, 32'h0);
    rx_deliver(8'h99, 1'b0, 1'b1, 32'h01);
    mmio_rd("rx_full_simul", 32'h08, 32'h00080006);
    rx_deliver(8'hEE, 1'b0, 1'b0, 32'h0);
    mmio_rd("rx_full_ovf", 32'h08, 32'h00080026);
    for (int i = 2; i <= RX_DEPTH; i++) mmio_rd($sformatf("rx_drain%0d", i), 32'h04, 32'(i));
    mmio_rd("rx_drain_last", 32'h04, 32'h99);
    mmio_rd("rx_drained_status", 32'h08, 32'h0000002A);

    // IRQ
    do_reset();
    mmio_wr(32'h10, 32'h1);
    cycles(2);
    check("irq_idle", {31'h0, irq}, 32'h0);
    @(negedge clk); rx_data = 8'h33; rx_flag = 1'b1;
    @(posedge clk); #1;
    check("irq_m1", {31'h0, irq}, 32'h0);
    check("irq_rx_clr", {31'h0, rx_flag_clr}, 32'h1);
    @(posedge clk); #1;
    check("irq_m2", {31'h0, irq}, 32'h1);
    rx_flag = 1'b0;
    n = 0;
    while (rx_flag_clr && n < 20) begin @(posedge clk); #1; n++; end
    mmio_rd("irq_rx_read", 32'h04, 32'h33);
    @(posedge clk); #1;
    check("irq_after_pop", {31'h0, irq}, 32'h0);
    mmio_wr(32'h10, 32'h4);
    cycles(2);
    check("irq_err_none", {31'h0, irq}, 32'h0);
    for (int i = 0; i < TX_DEPTH + 2; i++) mmio_wr(32'h00, 32'(i));
    cycles(2);
    check("irq_err_set", {31'h0, irq}, 32'h1);
    mmio_wr(32'h0C, 32'h40);
    cycles(2);
    check("irq_err_clr", {31'h0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
